// File: rtl/accel_pkg.sv
// Shared accelerator package: default sizes, Q8.8 format constants and the
// drain FSM state encoding used by output_drain_buffer.
package accel_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH   = 16;
  localparam int unsigned DEFAULT_BUFFER_DEPTH = 256;
  localparam int unsigned DEFAULT_ADDR_WIDTH   = 8;

  // Q8.8 result word format
  localparam int unsigned Q_INT_BITS  = 8;
  localparam int unsigned Q_FRAC_BITS = 8;
  localparam logic [15:0] Q_ONE       = 16'h0100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FINISH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/output_drain_buffer_if.sv
// Valid/ready stream carrying drained result words.
//   m_valid : word valid (master -> slave)
//   m_ready : slave accepts word (slave -> master)
//   m_data  : result word
//   m_last  : final word of the drain, qualified by m_valid
interface output_drain_buffer_if
  import accel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/drain_skid_fifo.sv
// Two-entry valid/ready skid FIFO. The head register drives the output
// directly so out_valid/out_data are registered and hold during stalls.
//   clk, rst_n         : clock, async active-low reset
//   in_valid, in_data  : push side (caller guarantees room)
//   out_valid, out_ready, out_data : pop side
//   count_c            : current occupancy (0..2)
module drain_skid_fifo #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count_c
);

  logic [WIDTH-1:0] tail_q;
  logic             tail_vld;
  logic             pop_c;

  assign pop_c   = out_valid & out_ready;
  assign count_c = {1'b0, out_valid} + {1'b0, tail_vld};

  // Head refills from tail first to preserve order; tail only ever holds a
  // word while the head is occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      tail_q    <= '0;
      tail_vld  <= 1'b0;
    end else if (!out_valid || pop_c) begin
      if (tail_vld) begin
        out_data  <= tail_q;
        out_valid <= 1'b1;
        tail_vld  <= in_valid;
        if (in_valid) tail_q <= in_data;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid) begin
      tail_q   <= in_data;
      tail_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/output_drain_buffer.sv
// Result buffer: compute unit writes words by address into a dual-port RAM;
// a start command drains a contiguous (wrapping) address range out over a
// valid/ready stream at up to one word per cycle.
//   clk, rst_n                 : clock, async active-low reset
//   wr_en, wr_addr, wr_data    : result write port (always active)
//   start, base_addr, length   : drain command, sampled only in IDLE
//   busy, done                 : drain in progress / one-cycle completion pulse
//   m_if                       : output stream (m_valid/m_ready/m_data/m_last)
module output_drain_buffer
  import accel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned BUFFER_DEPTH = DEFAULT_BUFFER_DEPTH,
  parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output_drain_buffer_if.master m_if
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  drain_state_e          state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  reads_left;
  logic                  rd_vld;
  logic                  rd_last;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];

  logic                  issue_c;
  logic                  pop_c;
  logic [1:0]            fifo_count_c;
  logic                  fifo_valid;
  logic [DATA_WIDTH:0]   fifo_out;

  assign pop_c = fifo_valid & m_if.m_ready;

  // Read only when the word can be guaranteed a skid slot. A pop in the same
  // cycle frees a slot, which is what keeps the stream at one word per cycle.
  assign issue_c = (state == ST_STREAM) && (reads_left != '0) &&
                   (((2'(rd_vld) + fifo_count_c) < 2'd2) || pop_c);

  // RAM: read-first on address collision; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en)   mem[wr_addr] <= wr_data;
    if (issue_c) rd_data      <= mem[rd_ptr];
  end

  // Drain FSM and read pipeline tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_ptr     <= '0;
      reads_left <= '0;
      rd_vld     <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      rd_vld  <= issue_c;
      rd_last <= issue_c && (reads_left == CNT_WIDTH'(1));
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (length != '0) begin
              rd_ptr     <= base_addr;
              reads_left <= length;
              busy       <= 1'b1;
              state      <= ST_STREAM;
            end else begin
              done  <= 1'b1;
              state <= ST_FINISH;
            end
          end
        end
        ST_STREAM: begin
          if (issue_c) begin
            rd_ptr     <= rd_ptr + ADDR_WIDTH'(1);
            reads_left <= reads_left - CNT_WIDTH'(1);
          end
          if (pop_c && m_if.m_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  drain_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_vld),
    .in_data   ({rd_last, rd_data}),
    .out_valid (fifo_valid),
    .out_ready (m_if.m_ready),
    .out_data  (fifo_out),
    .count_c   (fifo_count_c)
  );

  assign m_if.m_valid = fifo_valid;
  assign m_if.m_last  = fifo_out[DATA_WIDTH];
  assign m_if.m_data  = fifo_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_output_drain_buffer.sv
// Directed bench for output_drain_buffer: fill, backpressure, wrap, zero and
// full length, ignored start and reset mid-drain.
module tb_output_drain_buffer;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        busy;
  logic        done;

  output_drain_buffer_if #(.DATA_WIDTH(16)) m_if ();

  output_drain_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .m_if      (m_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] model_mem [256];
  logic [16:0] q [$];
  int          busy_seen;
  int          valid_seen;
  int          done_cnt;
  logic        stall_prev;
  logic [16:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    model_mem[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  // Beat collector and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(m_if.m_valid), 32'd1);
        chk("stall_word", 32'({m_if.m_last, m_if.m_data}), 32'(held));
      end
      if (m_if.m_valid && m_if.m_ready) q.push_back({m_if.m_last, m_if.m_data});
      stall_prev = m_if.m_valid && !m_if.m_ready;
      held       = {m_if.m_last, m_if.m_data};
      if (busy)        busy_seen++;
      if (m_if.m_valid) valid_seen++;
      if (done)        done_cnt++;
    end
  end

  task automatic drain(input logic [7:0] base, input int len, input bit bp,
                       input bit lat, input bit inj, input string tag);
    int          n;
    bit          seen;
    logic        prev_busy;
    logic [3:0]  pat;
    logic [7:0]  a;
    pat        = 4'b1001;
    q.delete();
    busy_seen  = 0;
    valid_seen = 0;
    done_cnt   = 0;
    base_addr  = base;
    length     = 9'(len);
    start      = 1'b1;
    m_if.m_ready = 1'b1;
    seen      = 1'b0;
    prev_busy = 1'b0;
    n         = 0;
    while (!seen && n < 2000) begin
      step();
      n++;
      if (n == 1) start = 1'b0;
      if (lat) begin
        if (n == 1) begin
          chk({tag, "_busy_e"}, 32'(busy), 32'd1);
          chk({tag, "_valid_e"}, 32'(m_if.m_valid), 32'd0);
        end
        if (n == 2) chk({tag, "_valid_e1"}, 32'(m_if.m_valid), 32'd0);
        if (n == 3) begin
          chk({tag, "_valid_e2"}, 32'(m_if.m_valid), 32'd1);
          chk({tag, "_data_e2"}, 32'(m_if.m_data), 32'(model_mem[base]));
        end
      end
      if (done) begin
        seen = 1'b1;
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        if (len > 0) chk({tag, "_busy_before_done"}, 32'(prev_busy), 32'd1);
        if (lat) chk({tag, "_done_cycle"}, 32'(n), 32'(len + 3));
      end
      prev_busy = busy;
      if (inj && n == 4) begin
        start     = 1'b1;
        base_addr = 8'd100;
        length    = 9'd5;
      end
      if (inj && n == 5) start = 1'b0;
      m_if.m_ready = bp ? pat[n[1:0]] : 1'b1;
    end
    if (!seen) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    m_if.m_ready = 1'b1;
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    repeat (6) step();
    chk({tag, "_beats"}, 32'(q.size()), 32'(len));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    if (len == 0) begin
      chk({tag, "_busy_seen"}, 32'(busy_seen), 32'd0);
      chk({tag, "_valid_seen"}, 32'(valid_seen), 32'd0);
    end
    for (int k = 0; k < len && k < q.size(); k++) begin
      a = base + 8'(k);
      chk({tag, "_word"}, 32'(q[k]), 32'({(k == len - 1), model_mem[a]}));
    end
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    start        = 1'b0;
    base_addr    = '0;
    length       = '0;
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(m_if.m_valid), 32'd0);
    chk("rst_last", 32'(m_if.m_last), 32'd0);
    chk("rst_data", 32'(m_if.m_data), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) wr(8'(i), 16'h1000 + 16'(i));
    drain(8'd0, 8, 1'b0, 1'b1, 1'b0, "fill");
    drain(8'd0, 8, 1'b1, 1'b0, 1'b0, "bp");

    wr(8'd254, 16'hAAAA);
    wr(8'd255, 16'hBBBB);
    wr(8'd0,   16'hCCCC);
    wr(8'd1,   16'hDDDD);
    drain(8'd254, 4, 1'b0, 1'b0, 1'b0, "wrap");

    drain(8'd0, 0, 1'b0, 1'b0, 1'b0, "zero");
    drain(8'd0, 8, 1'b1, 1'b0, 1'b1, "ign");

    // Reset mid-drain after three beats.
    q.delete();
    base_addr    = 8'd0;
    length       = 9'd8;
    start        = 1'b1;
    m_if.m_ready = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (q.size() < 3 && n < 50) begin
      step();
      n++;
    end
    chk("rst_mid_beats", 32'(q.size()), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(m_if.m_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_last", 32'(m_if.m_last), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    drain(8'd2, 4, 1'b1, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 256; i++) wr(8'(i), 16'h5A00 ^ 16'(i * 3));
    drain(8'd16, 256, 1'b0, 1'b0, 1'b0, "full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
